// File: rtl/sdc_rd_blk_sink.sv
// Sink for the SD single-block read engine: writes each 64-bit word into the data BRAM,
// folds the block payload through CRC16-CCITT and reports pass/fail to the ADMA2 sequencer.
module sdc_rd_blk_sink #(
   parameter int AW  = 9,
   parameter int WPB = 64
) (
   input  logic          sdc_clk,
   input  logic          reset,
   input  logic          blk_strt,
   input  logic [AW-1:0] blk_base_addr,
   input  logic          wrd_rdy_strb,
   input  logic [63:0]   dat_wrd,
   input  logic          crc_rdy_strb,
   input  logic [15:0]   crc_16,
   output logic          bram_we,
   output logic [AW-1:0] bram_addr,
   output logic [63:0]   bram_dat,
   output logic [6:0]    wrd_cnt,
   output logic          blk_done_strb,
   output logic          crc_ok,
   output logic          crc_err,
   output logic          ovr_err
);

   localparam logic [6:0] WPB_C = 7'(WPB);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CRC_RUN,
      S_CHECK
   } state_t;

   state_t        state_q,    state_d;
   logic [AW-1:0] base_q,     base_d;
   logic [6:0]    wrd_cnt_q,  wrd_cnt_d;
   logic [15:0]   crc_q,      crc_d;
   logic [15:0]   crc_rx_q,   crc_rx_d;
   logic          pend_q,     pend_d;
   logic [63:0]   shbuf_q,    shbuf_d;
   logic [2:0]    byte_cnt_q, byte_cnt_d;
   logic          bram_we_q,  bram_we_d;
   logic [AW-1:0] bram_addr_q, bram_addr_d;
   logic [63:0]   bram_dat_q, bram_dat_d;
   logic          crc_ok_q,   crc_ok_d;
   logic          crc_err_q,  crc_err_d;
   logic          ovr_err_q,  ovr_err_d;

   logic          accept;
   logic          blk_good;

   // One CRC16-CCITT step over a whole byte, MSB first, poly 0x1021.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   assign blk_good = (wrd_cnt_q == WPB_C) && (crc_q == crc_rx_q) && !ovr_err_q && !crc_err_q;

   always_comb begin
      // NOTE: every next-state variable takes its held value first, so no path can infer a latch.
      state_d     = state_q;
      base_d      = base_q;
      wrd_cnt_d   = wrd_cnt_q;
      crc_d       = crc_q;
      crc_rx_d    = crc_rx_q;
      pend_d      = pend_q;
      shbuf_d     = shbuf_q;
      byte_cnt_d  = byte_cnt_q;
      bram_we_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      bram_dat_d  = bram_dat_q;
      crc_ok_d    = crc_ok_q;
      crc_err_d   = crc_err_q;
      ovr_err_d   = ovr_err_q;
      accept      = 1'b0;

      if (blk_strt) begin
         // Re-arm from any state; a word strobed in the same cycle is dropped.
         state_d    = S_ARMED;
         base_d     = blk_base_addr;
         wrd_cnt_d  = '0;
         crc_d      = '0;
         pend_d     = 1'b0;
         byte_cnt_d = '0;
         crc_ok_d   = 1'b0;
         crc_err_d  = 1'b0;
         ovr_err_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
            end

            S_ARMED: begin
               if (wrd_rdy_strb) begin
                  if (wrd_cnt_q < WPB_C) begin
                     accept      = 1'b1;
                     bram_we_d   = 1'b1;
                     bram_addr_d = base_q + AW'(wrd_cnt_q);
                     bram_dat_d  = dat_wrd;
                     shbuf_d     = dat_wrd;
                     wrd_cnt_d   = wrd_cnt_q + 7'd1;
                     byte_cnt_d  = '0;
                     state_d     = S_CRC_RUN;
                  end else begin
                     crc_err_d = 1'b1;
                  end
               end
               if (crc_rdy_strb) begin
                  crc_rx_d = crc_16;
                  if (accept) begin
                     pend_d = 1'b1;
                  end else begin
                     state_d = S_CHECK;
                  end
               end
            end

            S_CRC_RUN: begin
               crc_d      = crc16_byte(crc_q, shbuf_q[63:56]);
               shbuf_d    = {shbuf_q[55:0], 8'h00};
               byte_cnt_d = byte_cnt_q + 3'd1;
               if (wrd_rdy_strb) begin
                  ovr_err_d = 1'b1;
               end
               if (crc_rdy_strb) begin
                  crc_rx_d = crc_16;
                  pend_d   = 1'b1;
               end
               if (byte_cnt_q == 3'd7) begin
                  state_d = (pend_q || crc_rdy_strb) ? S_CHECK : S_ARMED;
               end
            end

            S_CHECK: begin
               crc_ok_d  = blk_good;
               crc_err_d = !blk_good;
               pend_d    = 1'b0;
               state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
   always_ff @(posedge sdc_clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         wrd_cnt_q   <= '0;
         crc_q       <= '0;
         crc_rx_q    <= '0;
         pend_q      <= 1'b0;
         shbuf_q     <= '0;
         byte_cnt_q  <= '0;
         bram_we_q   <= 1'b0;
         bram_addr_q <= '0;
         bram_dat_q  <= '0;
         crc_ok_q    <= 1'b0;
         crc_err_q   <= 1'b0;
         ovr_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         wrd_cnt_q   <= wrd_cnt_d;
         crc_q       <= crc_d;
         crc_rx_q    <= crc_rx_d;
         pend_q      <= pend_d;
         shbuf_q     <= shbuf_d;
         byte_cnt_q  <= byte_cnt_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_dat_q  <= bram_dat_d;
         crc_ok_q    <= crc_ok_d;
         crc_err_q   <= crc_err_d;
         ovr_err_q   <= ovr_err_d;
      end
   end

   assign bram_we       = bram_we_q;
   assign bram_addr     = bram_addr_q;
   assign bram_dat      = bram_dat_q;
   assign wrd_cnt       = wrd_cnt_q;
   assign blk_done_strb = (state_q == S_CHECK);
   assign crc_ok        = crc_ok_q;
   assign crc_err       = crc_err_q;
   assign ovr_err       = ovr_err_q;

endmodule

// File: doc/sdc_rd_blk_sink.md
Name: sdc_rd_blk_sink

Overview:
- Downstream consumer of the SD-card single-block read engine.
- Takes each 64-bit data word strobed out by the read engine and writes it into the data BRAM at a block base address plus the word index.
- Runs the SD CRC16 over the 512-byte payload and compares it against the CRC16 captured from the card.
- Reports block completion and CRC pass/fail to the ADMA2 state machine; everything runs in the sdc_clk domain.

Parameters:
- AW, 9, BRAM word-address width.
- WPB, 64, 64-bit words per block (512 bytes).

Ports:
- sdc_clk  in  1  SD card clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- blk_strt  in  1  one-cycle strobe from ADMA2: arm for a new block.
- blk_base_addr  in  AW  BRAM word address of word 0; sampled on blk_strt.
- wrd_rdy_strb  in  1  one-cycle strobe: dat_wrd holds a complete word.
- dat_wrd  in  64  data word; bit 63 is the first bit received from the card.
- crc_rdy_strb  in  1  one-cycle strobe: crc_16 is valid.
- crc_16  in  16  CRC received from the card; bit 15 first received.
- bram_we  out  1  BRAM write enable, one-cycle pulse.
- bram_addr  out  AW  BRAM write address.
- bram_dat  out  64  BRAM write data.
- wrd_cnt  out  7  words accepted in the current block, 0..64.
- blk_done_strb  out  1  one-cycle pulse: block finished (pass or fail).
- crc_ok  out  1  CRC of the last finished block matched; held until next blk_strt.
- crc_err  out  1  mismatch, short block, or long block; held until next blk_strt.
- ovr_err  out  1  word arrived while the CRC engine was busy; sticky until blk_strt.

Behaviour:
- Reset: state IDLE. All outputs 0: bram_we, bram_addr, bram_dat, wrd_cnt, blk_done_strb, crc_ok, crc_err, ovr_err. CRC accumulator = 0x0000.
- States: IDLE, ARMED, CRC_RUN, CHECK.

State transitions:
- IDLE:
  - On blk_strt: latch blk_base_addr, clear wrd_cnt, CRC accumulator, crc_ok, crc_err and ovr_err; go to ARMED.
  - wrd_rdy_strb and crc_rdy_strb are ignored in IDLE.
- ARMED:
  - On wrd_rdy_strb with wrd_cnt < WPB, in the next cycle: bram_we=1, bram_addr = base + wrd_cnt (mod 2^AW, wraps), bram_dat = dat_wrd. Also wrd_cnt increments, the word is latched into the CRC shift buffer, and the state goes to CRC_RUN.
  - On wrd_rdy_strb with wrd_cnt == WPB: no write; set crc_err; stay.
  - On crc_rdy_strb: latch crc_16 and go to CHECK.
- CRC_RUN:
  - Exactly 8 cycles; each cycle folds one byte, MSB byte first (dat_wrd[63:56] first).
  - CRC16-CCITT: poly 0x1021, init 0x0000, MSB-first, no reflection, no final XOR.
  - After the 8th byte, return to ARMED.
  - wrd_rdy_strb during CRC_RUN: word dropped (no BRAM write, wrd_cnt unchanged); ovr_err=1.
  - crc_rdy_strb during CRC_RUN: latch crc_16 into a pending register and set a pending flag; after the 8th byte go to CHECK instead of ARMED.
- CHECK, one cycle:
  - blk_done_strb=1.
  - crc_ok=1 if wrd_cnt == WPB, the accumulator equals the latched crc, ovr_err==0, and crc_err==0.
  - Otherwise crc_err=1.
  - Go to IDLE.
- blk_strt in any non-IDLE state: abort the current block with no blk_done_strb and re-arm exactly as from IDLE.
- blk_strt and wrd_rdy_strb in the same cycle: blk_strt wins; the word is dropped.
- Reset mid-block: immediate return to reset values; any pending BRAM write is cancelled.
- crc_ok and crc_err are never both 1.
- Latencies:
  - wrd_rdy_strb to bram_we: exactly 1 cycle.
  - crc_rdy_strb to blk_done_strb: 1 cycle when ARMED; up to 9 cycles when it arrives during CRC_RUN.

Test Plan:
- blk_strt with base 0x040, then 64 words of 0xFFFFFFFFFFFFFFFF spaced 65 cycles, then crc_rdy_strb with crc_16 = 0x7FA1 -> 64 writes to addresses 0x040..0x07F; wrd_cnt = 64; blk_done_strb one cycle after crc_rdy_strb; crc_ok=1, crc_err=0.
- Same stimulus with crc_16 = 0x7FA0 -> blk_done_strb; crc_ok=0, crc_err=1; all 64 BRAM writes still occur.
- 64 all-zero words, crc_16 = 0x0000, crc_rdy_strb 3 cycles after the last wrd_rdy_strb -> CHECK entered after CRC_RUN completes (6 cycles later); crc_ok=1.
- Base 0x1F0 with 64 words -> bram_addr wraps 0x1FF then 0x000..0x02F; CRC still correct.
- Second wrd_rdy_strb 4 cycles after the first -> second word not written; wrd_cnt=1; ovr_err=1; crc_err=1 at CHECK.
- Only 10 words then crc_rdy_strb -> blk_done_strb, crc_err=1. Also: reset asserted after word 30 -> all outputs 0, state IDLE, and later wrd_rdy_strb ignored until blk_strt.
